// File: rtl/ide_sector_xfer_if.sv
// Command, byte-stream and buffer port-B signals of the sector transfer engine.
// The master side is the MCU plus the buffer; the slave side is the engine.
interface ide_sector_xfer_if #(
   parameter int ADDR_W   = 12,
   parameter int SEC_LOG2 = 8
);
   logic                       start;
   logic                       dir;
   logic [ADDR_W-SEC_LOG2-1:0] sector;
   logic [4:0]                 count;
   logic                       abort;
   logic [7:0]                 in_byte;
   logic                       in_stb;
   logic [7:0]                 out_byte;
   logic                       out_valid;
   logic                       out_ready;
   logic [ADDR_W-1:0]          ram_addr;
   logic [15:0]                ram_din;
   logic                       ram_ce;
   logic                       ram_we;
   logic [15:0]                ram_dout;
   logic                       busy;
   logic                       done;

   modport master (
      output start, dir, sector, count, abort,
      output in_byte, in_stb, out_ready, ram_dout,
      input  out_byte, out_valid, ram_addr, ram_din,
      input  ram_ce, ram_we, busy, done
   );

   modport slave (
      input  start, dir, sector, count, abort,
      input  in_byte, in_stb, out_ready, ram_dout,
      output out_byte, out_valid, ram_addr, ram_din,
      output ram_ce, ram_we, busy, done
   );
endinterface

// File: rtl/ide_sector_xfer.sv
// Byte-stream <-> sector-buffer transfer engine on port B of the IDE buffer.
// Packs MCU bytes into 16-bit words on writes, unpacks words into bytes on reads.
module ide_sector_xfer #(
   parameter int ADDR_W    = 12,
   parameter int SEC_LOG2  = 8,
   parameter bit BYTE_SWAP = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   ide_sector_xfer_if.slave bus
);
   localparam int WORDS_W = SEC_LOG2 + 5;

   typedef enum logic [3:0] {
      IDLE,
      WR_FIRST,
      WR_SECOND,
      WR_COMMIT,
      RD_ISSUE,
      RD_WAIT,
      RD_FIRST,
      RD_SECOND,
      DONE
   } state_t;

   state_t             state, state_n;
   logic [ADDR_W-1:0]  addr, addr_n;
   logic [WORDS_W-1:0] words, words_n;
   logic [15:0]        word, word_n;
   logic [7:0]         obyte, obyte_n;
   logic               ovalid, ovalid_n;
   logic [4:0]         cnt_eff;
   logic               last;

   // BYTE_SWAP picks which half of the word holds the first byte of a pair
   function automatic logic [15:0] put_byte(
      input logic [15:0] w,
      input logic [7:0]  b,
      input logic        first
   );
      if (first ^ BYTE_SWAP)
         return {b, w[7:0]};
      return {w[15:8], b};
   endfunction

   function automatic logic [7:0] get_byte(
      input logic [15:0] w,
      input logic        first
   );
      return (first ^ BYTE_SWAP) ? w[15:8] : w[7:0];
   endfunction

   assign cnt_eff = (bus.count == 5'd0) ? 5'd16 : bus.count;
   assign last    = (words == WORDS_W'(1));

   always_comb begin
      state_n  = state;
      addr_n   = addr;
      words_n  = words;
      word_n   = word;
      obyte_n  = obyte;
      ovalid_n = 1'b0;
      if (bus.abort) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  state_n = bus.dir ? RD_ISSUE : WR_FIRST;
                  addr_n  = {bus.sector, {SEC_LOG2{1'b0}}};
                  words_n = WORDS_W'(cnt_eff) << SEC_LOG2;
               end
            end
            WR_FIRST: begin
               if (bus.in_stb) begin
                  word_n  = put_byte(word, bus.in_byte, 1'b1);
                  state_n = WR_SECOND;
               end
            end
            WR_SECOND: begin
               if (bus.in_stb) begin
                  word_n  = put_byte(word, bus.in_byte, 1'b0);
                  state_n = WR_COMMIT;
               end
            end
            WR_COMMIT: begin
               addr_n  = addr + ADDR_W'(1);
               words_n = words - WORDS_W'(1);
               // a strobe during the commit already starts the next word
               if (last) begin
                  state_n = DONE;
               end else if (bus.in_stb) begin
                  word_n  = put_byte(word, bus.in_byte, 1'b1);
                  state_n = WR_SECOND;
               end else begin
                  state_n = WR_FIRST;
               end
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT: begin
               word_n   = bus.ram_dout;
               addr_n   = addr + ADDR_W'(1);
               obyte_n  = get_byte(bus.ram_dout, 1'b1);
               ovalid_n = 1'b1;
               state_n  = RD_FIRST;
            end
            RD_FIRST: begin
               ovalid_n = 1'b1;
               if (bus.out_ready) begin
                  obyte_n = get_byte(word, 1'b0);
                  state_n = RD_SECOND;
               end
            end
            RD_SECOND: begin
               if (bus.out_ready) begin
                  words_n = words - WORDS_W'(1);
                  state_n = last ? DONE : RD_ISSUE;
               end else begin
                  ovalid_n = 1'b1;
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         addr   <= '0;
         words  <= '0;
         word   <= '0;
         obyte  <= '0;
         ovalid <= 1'b0;
      end else begin
         state  <= state_n;
         addr   <= addr_n;
         words  <= words_n;
         word   <= word_n;
         obyte  <= obyte_n;
         ovalid <= ovalid_n;
      end
   end

   // abort gates the buffer strobes in the very cycle it arrives
   assign bus.ram_ce    = !bus.abort &&
                          (state == WR_COMMIT || state == RD_ISSUE);
   assign bus.ram_we    = !bus.abort && (state == WR_COMMIT);
   assign bus.ram_addr  = addr;
   assign bus.ram_din   = word;
   assign bus.out_byte  = obyte;
   assign bus.out_valid = ovalid;
   assign bus.busy      = (state != IDLE) && (state != DONE);
   assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_ide_sector_xfer.sv
// Directed bench for ide_sector_xfer with a 4096x16 buffer model on port B.
// Write transfers are table-driven; reset, read and abort corners are hand-written.
module tb_ide_sector_xfer;
   logic clk = 1'b0;
   logic reset;

   ide_sector_xfer_if #(.ADDR_W(12), .SEC_LOG2(8)) bus ();

   ide_sector_xfer #(
      .ADDR_W(12),
      .SEC_LOG2(8),
      .BYTE_SWAP(1'b0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  sec;
      logic [4:0]  cnt;
      int          nbytes;
      int          gap;
      bit          do_abort;
      int          poke;
      int          exp_writes;
      int          exp_done;
      logic [11:0] exp_first;
   } xfer_t;

   xfer_t       vec [5];
   logic [15:0] mem [4096];
   logic [15:0] exp_mem [4096];
   logic [11:0] wr_log [8192];
   int          wr_total = 0;
   int          done_total = 0;
   int          done_busy = 0;
   logic        init_fill = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   // buffer model: registered read, data valid the cycle after ram_ce
   always @(posedge clk) begin
      if (init_fill) begin
         for (int i = 0; i < 4096; i++)
            mem[i] <= 16'(i) ^ 16'hA5C3;
      end else if (bus.ram_ce && bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_din;
         wr_log[wr_total[12:0]] <= bus.ram_addr;
         wr_total <= wr_total + 1;
      end else if (bus.ram_ce) begin
         bus.ram_dout <= mem[bus.ram_addr];
      end
      if (bus.done)
         done_total <= done_total + 1;
      if (bus.done && bus.busy)
         done_busy <= done_busy + 1;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int v, input int i);
      if (v == 0)
         return 8'(i);
      return 8'(i * 13 + v * 29 + 7);
   endfunction

   function automatic int mem_diffs();
      int bad = 0;
      for (int i = 0; i < 4096; i++)
         if (mem[i] !== exp_mem[i])
            bad++;
      return bad;
   endfunction

   task automatic run_write(input int v);
      int          mw, md, seq, nwords;
      logic [11:0] a;
      mw = wr_total;
      md = done_total;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.dir    = 1'b0;
      bus.sector = vec[v].sec;
      bus.count  = vec[v].cnt;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < vec[v].nbytes; i++) begin
         bus.in_byte = pat(v, i);
         bus.in_stb  = 1'b1;
         if (i == vec[v].poke) begin
            bus.start  = 1'b1;
            bus.dir    = 1'b1;
            bus.count  = 5'd3;
            bus.sector = 4'd9;
         end
         @(negedge clk);
         bus.in_stb = 1'b0;
         bus.start  = 1'b0;
         bus.dir    = 1'b0;
         repeat (vec[v].gap) @(negedge clk);
      end
      if (vec[v].do_abort) begin
         bus.abort = 1'b1;
         @(negedge clk);
         bus.abort = 1'b0;
         check($sformatf("v%0d busy_after_abort", v), 32'(bus.busy), 0);
         repeat (4) @(negedge clk);
      end else begin
         for (int c = 0; c < 16 && done_total == md; c++)
            @(negedge clk);
      end
      nwords = vec[v].nbytes / 2;
      for (int k = 0; k < nwords; k++) begin
         a = {vec[v].sec, 8'h00} + 12'(k);
         exp_mem[a] = {pat(v, 2 * k), pat(v, 2 * k + 1)};
      end
      seq = 0;
      for (int k = 1; k < wr_total - mw; k++)
         if (wr_log[13'(mw + k)] != wr_log[13'(mw + k - 1)] + 12'd1)
            seq++;
      check($sformatf("v%0d writes", v), 32'(wr_total - mw),
            32'(vec[v].exp_writes));
      check($sformatf("v%0d first_addr", v), 32'(wr_log[13'(mw)]),
            32'(vec[v].exp_first));
      check($sformatf("v%0d addr_seq", v), 32'(seq), 0);
      check($sformatf("v%0d done_pulses", v), 32'(done_total - md),
            32'(vec[v].exp_done));
      check($sformatf("v%0d busy_end", v), 32'(bus.busy), 0);
      check($sformatf("v%0d mem_diffs", v), 32'(mem_diffs()), 0);
   endtask

   task automatic run_read(input logic [3:0] sec, input logic [4:0] cnt);
      int          nexp, got, bad, unstable, lat, md, extra;
      logic        rdy, hold;
      logic [7:0]  prev_b, eb;
      logic [15:0] w;
      logic [11:0] a;
      nexp = ((cnt == 5'd0) ? 16 : int'(cnt)) * 512;
      md = done_total;
      got = 0; bad = 0; unstable = 0; lat = 0; extra = 0;
      hold = 1'b0;
      prev_b = 8'h00;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.dir       = 1'b1;
      bus.sector    = sec;
      bus.count     = cnt;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      // c numbers clock cycles with the start cycle as cycle 1
      for (int c = 2; c < 20000; c++) begin
         if (got == nexp && done_total != md)
            break;
         if (bus.out_valid && lat == 0)
            lat = c;
         if (hold && (!bus.out_valid || bus.out_byte != prev_b))
            unstable++;
         rdy = 1'($urandom_range(0, 1));
         bus.out_ready = rdy;
         if (bus.out_valid && rdy) begin
            a  = {sec, 8'h00} + 12'(got / 2);
            w  = exp_mem[a];
            eb = (got % 2 == 0) ? w[15:8] : w[7:0];
            if (bus.out_byte != eb)
               bad++;
            got++;
         end
         hold   = bus.out_valid && !rdy;
         prev_b = bus.out_byte;
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      repeat (4) begin
         if (bus.out_valid)
            extra++;
         @(negedge clk);
      end
      bus.out_ready = 1'b0;
      check("rd bytes", 32'(got), 32'(nexp));
      check("rd data", 32'(bad), 0);
      check("rd stable", 32'(unstable), 0);
      check("rd latency", 32'(lat), 4);
      check("rd extra", 32'(extra), 0);
      check("rd done", 32'(done_total - md), 1);
      check("rd busy_end", 32'(bus.busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int mw, vw;
      vec[0] = '{4'd2,  5'd1, 512,  0, 1'b0, -1, 256,  1, 12'h200};
      vec[1] = '{4'd15, 5'd2, 1024, 1, 1'b0, -1, 512,  1, 12'hF00};
      vec[2] = '{4'd5,  5'd1, 101,  0, 1'b1, -1, 50,   0, 12'h500};
      vec[3] = '{4'd7,  5'd1, 512,  2, 1'b0, 200, 256, 1, 12'h700};
      vec[4] = '{4'd0,  5'd0, 8192, 0, 1'b0, -1, 4096, 1, 12'h000};
      for (int i = 0; i < 4096; i++)
         exp_mem[i] = 16'(i) ^ 16'hA5C3;

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.dir       = 1'b0;
      bus.sector    = '0;
      bus.count     = '0;
      bus.abort     = 1'b0;
      bus.in_byte   = '0;
      bus.in_stb    = 1'b0;
      bus.out_ready = 1'b0;
      init_fill     = 1'b1;
      @(negedge clk);
      init_fill = 1'b0;
      @(negedge clk);
      check("rst flags", 32'({bus.busy, bus.done, bus.out_valid,
                              bus.ram_ce, bus.ram_we}), 0);
      check("rst ram_addr", 32'(bus.ram_addr), 0);
      check("rst ram_din", 32'(bus.ram_din), 0);
      check("rst out_byte", 32'(bus.out_byte), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 4; v++)
         run_write(v);

      // reset while a read byte is being held
      @(negedge clk);
      bus.start  = 1'b1;
      bus.dir    = 1'b1;
      bus.sector = 4'd2;
      bus.count  = 5'd1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 10 && !bus.out_valid; c++)
         @(negedge clk);
      check("pre_rst out_valid", 32'(bus.out_valid), 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst out_valid", 32'(bus.out_valid), 0);
      check("async_rst busy", 32'(bus.busy), 0);
      check("async_rst ram_ce", 32'(bus.ram_ce), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_read(4'd2, 5'd1);

      // start and abort together in idle
      mw = wr_total;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.abort  = 1'b1;
      bus.dir    = 1'b0;
      bus.sector = 4'd3;
      bus.count  = 5'd1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("start_abort busy", 32'(bus.busy), 0);
      bus.in_byte = 8'h5A;
      bus.in_stb  = 1'b1;
      repeat (6) @(negedge clk);
      bus.in_stb = 1'b0;
      vw = wr_total - mw;
      check("start_abort writes", 32'(vw), 0);

      run_write(4);
      check("done_with_busy", 32'(done_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
